// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file, operand forwarding/bypass, load-use
// hazard detection, immediate decode and a valid/ready output register toward EX.
module id_stage_pipe #(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_fwd_en,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_fwd_addr,
  input  logic [XLEN-1:0] ex_fwd_data,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_wen,
  output logic            stall
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic            w_uses_rs2;
  logic            w_is_sb;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_accept;

  assign w_opcode = in_inst[6:0];
  assign w_rs1    = in_inst[15 +: AW];
  assign w_rs2    = in_inst[20 +: AW];
  assign w_rd     = in_inst[7 +: AW];
  assign w_is_sb  = (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
  assign w_uses_rs2 = w_is_sb || (w_opcode == OP_REG) || (w_opcode == OP_REG32);

  // Non-load EX result beats same-cycle writeback, which beats the array.
  function automatic logic [XLEN-1:0] sel_operand(input logic [AW-1:0]   rs,
                                                  input logic [XLEN-1:0] arr_val);
    if (rs == '0)
      return '0;
    else if (ex_fwd_en && !ex_is_load && (ex_fwd_addr == rs))
      return ex_fwd_data;
    else if (wb_en && (wb_addr == rs))
      return wb_data;
    else
      return arr_val;
  endfunction

  assign w_rs1_val = sel_operand(w_rs1, r_regs[w_rs1]);
  assign w_rs2_val = sel_operand(w_rs2, r_regs[w_rs2]);

  assign stall = in_valid && ex_is_load && (ex_fwd_addr != '0) &&
                 ((ex_fwd_addr == w_rs1) || (w_uses_rs2 && (ex_fwd_addr == w_rs2)));
  assign in_ready = (!out_valid || out_ready) && !stall && !flush;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      OP_STORE:
        w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      OP_BRANCH:
        w_imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'h000};
      OP_JAL:
        w_imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Output register: flush beats accept, accept beats drain; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'h0000_0000;
      out_pc      <= RESET_PC;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_wen     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      out_inst    <= in_inst;
      out_pc      <= in_pc;
      out_rs1_val <= w_rs1_val;
      out_rs2_val <= w_rs2_val;
      out_rd      <= w_rd;
      out_imm     <= w_imm;
      out_wen     <= (w_rd != '0) && !w_is_sb;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe.
module tb_id_stage_pipe;
  localparam int              XLEN  = 64;
  localparam int              AW    = 5;
  localparam logic [XLEN-1:0] RST_PC = 64'h0000_0000_0000_1000;

  localparam logic [31:0] I_ADDI_X1_X3_M1 = 32'hFFF18093;
  localparam logic [31:0] I_ADDI_X1_X5_0  = 32'h00028093;
  localparam logic [31:0] I_ADD_X5_X6_X7  = 32'h007302B3;
  localparam logic [31:0] I_SW_X0_8_X2    = 32'h00012423;
  localparam logic [31:0] I_LUI_X2        = 32'h80000137;
  localparam logic [31:0] I_JAL_X0_8      = 32'h0080006F;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0]     in_inst, out_inst;
  logic [XLEN-1:0] in_pc, out_pc, wb_data, ex_fwd_data;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val, out_imm;
  logic            wb_en, ex_fwd_en, ex_is_load, out_wen, stall;
  logic [AW-1:0]   wb_addr, ex_fwd_addr, out_rd;

  int n_pass = 0;
  int n_total = 0;

  id_stage_pipe #(.XLEN(XLEN), .NREGS(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_fwd_en(ex_fwd_en), .ex_is_load(ex_is_load), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_imm(out_imm), .out_wen(out_wen), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 1'b0; in_inst = 32'h0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_fwd_en = 1'b0; ex_is_load = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    step();
    n_total++;
    if (out_valid !== 1'b0 || out_pc !== RST_PC)
      $display("FAIL reset_state: out_valid=%b out_pc=%h want 0/%h", out_valid, out_pc, RST_PC);
    else n_pass++;
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h55;
    step();
    wb_en = 1'b0;
    in_valid = 1'b1; in_inst = I_ADDI_X1_X5_0; in_pc = 64'h200; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'h55)
      $display("FAIL pre_reset_load: valid=%b rs1=%h want 1/55", out_valid, out_rs1_val);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_pc !== RST_PC || out_inst !== 32'h0)
      $display("FAIL reset_midflight: valid=%b pc=%h inst=%h want 0/%h/0", out_valid, out_pc, out_inst, RST_PC);
    else n_pass++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = I_ADDI_X1_X5_0; in_pc = 64'h204;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'h0)
      $display("FAIL reset_regfile_x5: valid=%b rs1=%h want 1/0", out_valid, out_rs1_val);
    else n_pass++;
    step();
  endtask

  task automatic test_wb_bypass();
    quiet();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hDEAD;
    in_valid = 1'b1; in_inst = I_ADDI_X1_X3_M1; in_pc = 64'h100;
    step();
    quiet();
    n_total++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'hDEAD || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF ||
        out_rd !== 5'd1 || out_wen !== 1'b1 || out_pc !== 64'h100)
      $display("FAIL wb_bypass: v=%b rs1=%h imm=%h rd=%0d wen=%b pc=%h want 1/dead/ffff_ffff_ffff_ffff/1/1/100",
               out_valid, out_rs1_val, out_imm, out_rd, out_wen, out_pc);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL drain_empty: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    quiet();
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd3; ex_fwd_data = 64'd7;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd9;
    in_valid = 1'b1; in_inst = I_ADDI_X1_X3_M1; in_pc = 64'h104;
    step();
    n_total++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'd7)
      $display("FAIL ex_fwd_priority: v=%b rs1=%0d want 1/7", out_valid, out_rs1_val);
    else n_pass++;
    wb_en = 1'b0; ex_is_load = 1'b1; in_pc = 64'h108;
    #1;
    n_total++;
    if (stall !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL load_use_stall: stall=%b in_ready=%b want 1/0", stall, in_ready);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL stall_bubble: out_valid=%b want 0", out_valid);
    else n_pass++;
    ex_is_load = 1'b0; ex_fwd_en = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd9;
    #1;
    n_total++;
    if (stall !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: stall=%b in_ready=%b want 0/1", stall, in_ready);
    else n_pass++;
    step();
    quiet();
    n_total++;
    if (out_valid !== 1'b1 || out_rs1_val !== 64'd9 || out_pc !== 64'h108)
      $display("FAIL after_stall: v=%b rs1=%0d pc=%h want 1/9/108", out_valid, out_rs1_val, out_pc);
    else n_pass++;
    step();
  endtask

  task automatic test_hazard_formats();
    quiet();
    ex_is_load = 1'b1; ex_fwd_en = 1'b1; ex_fwd_addr = 5'd31;
    in_valid = 1'b1; in_inst = I_ADDI_X1_X3_M1;
    #1;
    n_total++;
    if (stall !== 1'b0)
      $display("FAIL i_fmt_rs2_ignored: stall=%b want 0", stall);
    else n_pass++;
    ex_fwd_addr = 5'd7; in_inst = I_ADD_X5_X6_X7;
    #1;
    n_total++;
    if (stall !== 1'b1)
      $display("FAIL r_fmt_rs2_stall: stall=%b want 1", stall);
    else n_pass++;
    ex_fwd_addr = 5'd0; in_inst = I_SW_X0_8_X2;
    #1;
    n_total++;
    if (stall !== 1'b0)
      $display("FAIL x0_no_stall: stall=%b want 0", stall);
    else n_pass++;
    in_valid = 1'b0;
    #1;
    n_total++;
    ex_fwd_addr = 5'd7; in_inst = I_ADD_X5_X6_X7;
    #1;
    if (stall !== 1'b0)
      $display("FAIL stall_needs_valid: stall=%b want 0", stall);
    else n_pass++;
    quiet();
  endtask

  task automatic test_backpressure();
    quiet();
    in_valid = 1'b1; in_inst = I_ADDI_X1_X5_0; in_pc = 64'h300; out_ready = 1'b0;
    step();
    in_inst = I_ADD_X5_X6_X7; in_pc = 64'h304;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h300 || out_inst !== I_ADDI_X1_X5_0)
        $display("FAIL backpressure_hold[%0d]: rdy=%b v=%b pc=%h inst=%h want 0/1/300/%h",
                 i, in_ready, out_valid, out_pc, out_inst, I_ADDI_X1_X5_0);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1)
      $display("FAIL backpressure_release: in_ready=%b want 1", in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_pc !== 64'h304 || out_inst !== I_ADD_X5_X6_X7)
      $display("FAIL backpressure_next: v=%b pc=%h inst=%h want 1/304/%h", out_valid, out_pc, out_inst, I_ADD_X5_X6_X7);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL no_duplicate: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    quiet();
    in_valid = 1'b1; in_inst = I_ADDI_X1_X5_0; in_pc = 64'h400;
    step();
    in_inst = I_ADD_X5_X6_X7; in_pc = 64'h404; out_ready = 1'b0; flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 64'h66;
    #1;
    n_total++;
    if (in_ready !== 1'b0)
      $display("FAIL flush_in_ready: in_ready=%b want 0", in_ready);
    else n_pass++;
    step();
    quiet();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_kill: out_valid=%b want 0", out_valid);
    else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_no_accept: out_valid=%b want 0", out_valid);
    else n_pass++;
    in_valid = 1'b1; in_inst = I_ADD_X5_X6_X7; in_pc = 64'h408;
    step();
    quiet();
    n_total++;
    if (out_rs1_val !== 64'h66 || out_rs2_val !== 64'h0 || out_rd !== 5'd5 || out_wen !== 1'b1)
      $display("FAIL flush_wb_kept: rs1=%h rs2=%h rd=%0d wen=%b want 66/0/5/1", out_rs1_val, out_rs2_val, out_rd, out_wen);
    else n_pass++;
    step();
  endtask

  task automatic test_decode();
    quiet();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hBAD;
    in_valid = 1'b1; in_inst = I_SW_X0_8_X2; in_pc = 64'h500;
    step();
    wb_en = 1'b0;
    n_total++;
    if (out_rs2_val !== 64'h0 || out_wen !== 1'b0 || out_imm !== 64'd8)
      $display("FAIL store_decode: rs2=%h wen=%b imm=%h want 0/0/8", out_rs2_val, out_wen, out_imm);
    else n_pass++;
    in_inst = I_LUI_X2;
    step();
    n_total++;
    if (out_imm !== 64'hFFFF_FFFF_8000_0000 || out_rd !== 5'd2 || out_wen !== 1'b1)
      $display("FAIL lui_decode: imm=%h rd=%0d wen=%b want ffffffff80000000/2/1", out_imm, out_rd, out_wen);
    else n_pass++;
    in_inst = I_JAL_X0_8;
    step();
    quiet();
    n_total++;
    if (out_imm !== 64'd8 || out_wen !== 1'b0)
      $display("FAIL jal_rd0_decode: imm=%h wen=%b want 8/0", out_imm, out_wen);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_forwarding();
    test_hazard_formats();
    test_backpressure();
    test_flush();
    test_decode();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage with an integrated register file and an output pipeline register toward EX.
- Accepts one instruction per cycle from IF over a valid/ready handshake.
- Reads operands with EX-forwarding and writeback bypass, decodes rd/immediate/wen.
- Stalls on load-use hazards and supports flush on branch redirect.

Parameters:
- XLEN, 64, datapath/register width.
- NREGS, 32, architectural register count (power of 2, ≤ 32); address width AW = log2(NREGS).
- RESET_PC, 0, value driven on out_pc while empty/after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF presents instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX accepts payload
- flush  in  1  kill registered and incoming instruction
- wb_en  in  1  writeback enable
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback value
- ex_fwd_en  in  1  EX result available for forwarding
- ex_is_load  in  1  instruction in EX is a load (data not ready)
- ex_fwd_addr  in  AW  EX destination register
- ex_fwd_data  in  XLEN  EX result
- out_inst  out  32  registered instruction
- out_pc  out  XLEN  registered PC
- out_rs1_val  out  XLEN  operand 1
- out_rs2_val  out  XLEN  operand 2
- out_rd  out  AW  destination register
- out_imm  out  XLEN  sign-extended immediate
- out_wen  out  1  instruction writes rd (rd != 0 and format writes)
- stall  out  1  load-use hazard detected this cycle

Behaviour:
- Reset (async, any time):
  - out_valid = 0; out_inst/out_rd/out_imm/out_wen/operands = 0; out_pc = RESET_PC.
  - All registers cleared to 0.
  - An in-flight instruction is dropped.
- Register file:
  - NREGS×XLEN array; x0 reads 0 always; writes to x0 ignored.
  - Write on posedge when wb_en.
- Operand select per source (rs = inst[19:15] / [24:20], truncated to AW), priority order:
  - rs == 0 → 0.
  - ex_fwd_en && !ex_is_load && ex_fwd_addr == rs → ex_fwd_data.
  - wb_en && wb_addr == rs → wb_data (same-cycle write-through).
  - otherwise array value.
- Hazard:
  - stall = in_valid && ex_is_load && ex_fwd_addr != 0 && ex_fwd_addr matches a source.
  - Match is checked for rs1 always; for rs2 only on R/S/B formats.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !stall && !flush.
  - Accept = in_valid && in_ready → next cycle out_* loaded, out_valid = 1.
  - Latency: 1 cycle.
  - If out_valid && out_ready and no accept → out_valid = 0.
  - If out_valid && !out_ready → all out_* held stable.
- Flush:
  - Next cycle out_valid = 0; wins over accept and hold.
  - Register file writes still occur.
- Decode, opcode[6:0]:
  - I (0000011, 0010011, 0011011, 1100111), S (0100011), B (1100011), U (0110111, 0010111), J (1101111); others → imm 0.
  - All immediates sign-extended to XLEN.
  - out_wen = 0 for S/B formats or rd == 0.
- Stall cycle: no accept; the output register behaves per the handshake rule (drains if out_ready), inserting a bubble.
- Stall clears the cycle after EX's load leaves (ex_is_load drops); the instruction is then accepted with the forwarded/bypassed value.

Test Plan:
- Reset mid-transfer: assert rst while out_valid=1 → out_valid=0, out_pc=RESET_PC immediately. Read x5 after release → 0.
- Writeback bypass: wb_en=1, wb_addr=3, wb_data=0xDEAD, accept "addi x1,x3,-1" (0xFFF18093) same cycle → next cycle out_rs1_val=0xDEAD, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_rd=1, out_wen=1.
- EX forwarding priority: ex_fwd_en=1, addr=3, data=7 and wb_addr=3, data=9 → rs1=7. Same with ex_is_load=1 → stall=1, in_ready=0. Drop ex_is_load, wb 3←9 → accepted next, rs1=9.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* unchanged. Raise out_ready → next instruction loaded after 1 cycle, no loss or duplication.
- Flush: flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0, incoming instruction not accepted.
- x0 and store decode: "sw x0,8(x2)" with wb_en to x0 → rs2=0, out_wen=0, out_imm=8.
